// File: rtl/fp_pkg.sv
// Shared constants, FSM encoding and small decode helpers for the RV32IF
// FP issue/hazard controller.
package fp_pkg;

  localparam logic [6:0] OP_FP   = 7'b1010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_FLW  = 7'b0000111;

  localparam logic [4:0] F5_FDIV  = 5'b00011;
  localparam logic [4:0] F5_FSQRT = 5'b01011;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fp_state_e;

  // A divide/sqrt only needs the EX hold when its latency exceeds one cycle.
  function automatic logic is_multi_op(
    input logic [6:0] op,
    input logic [4:0] f5,
    input logic       div_en,
    input logic       sqrt_en
  );
    return (op == OP_FP) &&
           (((f5 == F5_FDIV) && div_en) || ((f5 == F5_FSQRT) && sqrt_en));
  endfunction

  function automatic logic is_load_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_FLW);
  endfunction

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// ID/EX hazard bundle between the pipeline datapath (master) and the
// issue controller (slave).
interface fp_issue_ctrl_if;

  // ID-stage decode
  logic [6:0] OpD;
  logic [4:0] Funct5D;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic       Rs1FD;
  logic       Rs2FD;

  // EX-stage destination info
  logic [4:0] RdE;
  logic       RegWriteE;
  logic       RegWriteFE;
  logic       ResultSrcE0;
  logic       PCSrcE;

  // pipeline control back to the datapath
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic       fpu_start;
  logic       fpu_busy;

  modport master (
    output OpD, Funct5D, Rs1D, Rs2D, Rs1FD, Rs2FD,
    output RdE, RegWriteE, RegWriteFE, ResultSrcE0, PCSrcE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  fpu_start, fpu_busy
  );

  modport slave (
    input  OpD, Funct5D, Rs1D, Rs2D, Rs1FD, Rs2FD,
    input  RdE, RegWriteE, RegWriteFE, ResultSrcE0, PCSrcE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output fpu_start, fpu_busy
  );

endinterface

// File: rtl/fpu_lat_counter.sv
// Down-counter that times the remaining EX-hold cycles of a multi-cycle FP op.
module fpu_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/fp_issue_ctrl.sv
// ID->EX issue/hazard controller: load-use stall, taken-branch flush and the
// EX hold for multi-cycle fdiv.s / fsqrt.s with a registered FPU start pulse.
module fp_issue_ctrl
  import fp_pkg::*;
#(
  parameter int DIV_LAT  = 8,
  parameter int SQRT_LAT = 12,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_issue_ctrl_if.slave hz
);

  localparam logic DIV_MC  = (DIV_LAT > 1);
  localparam logic SQRT_MC = (SQRT_LAT > 1);

  // The BUSY window lasts LAT-1 cycles, so the counter starts at LAT-2.
  localparam logic [CNT_W-1:0] DIV_LOAD  = DIV_MC  ? CNT_W'(DIV_LAT - 2)  : '0;
  localparam logic [CNT_W-1:0] SQRT_LOAD = SQRT_MC ? CNT_W'(SQRT_LAT - 2) : '0;

  fp_state_e        state_reg, state_next;
  logic             start_reg, start_next;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  logic [4:0]       src_idx [2];
  logic [1:0]       src_fp;
  logic [1:0]       int_hit;
  logic [1:0]       fp_hit;
  logic             load_use;
  logic             multi_op;

  logic stall_f, stall_d, stall_e;
  logic flush_d, flush_e, flush_m;

  assign src_idx[0] = hz.Rs1D;
  assign src_idx[1] = hz.Rs2D;
  assign src_fp[0]  = hz.Rs1FD;
  assign src_fp[1]  = hz.Rs2FD;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign int_hit[gi] = (hz.RdE == src_idx[gi]) && !src_fp[gi];
      assign fp_hit[gi]  = (hz.RdE == src_idx[gi]) &&  src_fp[gi];
    end
  endgenerate

  // x0 never carries a hazard, but f0 is an ordinary FP register.
  assign load_use = hz.ResultSrcE0 &&
                    ((hz.RegWriteE && (hz.RdE != 5'd0) && (|int_hit)) ||
                     (hz.RegWriteFE && (|fp_hit)));

  assign multi_op = is_multi_op(hz.OpD, hz.Funct5D, DIV_MC, SQRT_MC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= start_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    start_next   = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_m      = 1'b0;

    case (state_reg)
      BUSY: begin
        // Freeze F/D/E around the FPU op and feed bubbles into MEM.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
        if (cnt_zero) begin
          state_next = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        if (hz.PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else if (multi_op) begin
          state_next   = BUSY;
          start_next   = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = (hz.Funct5D == F5_FSQRT) ? SQRT_LOAD : DIV_LOAD;
        end
      end
    endcase
  end

  fpu_lat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushM    = flush_m;
  assign hz.fpu_start = start_reg;
  assign hz.fpu_busy  = (state_reg == BUSY);

endmodule
